// File: rtl/pdl_puf_sequencer.sv
// Sequencer for the 16-instance PDL PUF array: runs NUM_EVALS reset/settle/fire/sample
// evaluations per challenge and returns a majority-voted response plus a stability mask.
module pdl_puf_sequencer #(
  parameter int NUM_PUF       = 16,
  parameter int CHAL_W        = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int EVAL_CYCLES   = 16,
  parameter int NUM_EVALS     = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               abort,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CHAL_W-1:0]  req_chal_top,
  input  logic [CHAL_W-1:0]  req_chal_bottom,
  output logic [CHAL_W-1:0]  puf_chal_up,
  output logic [CHAL_W-1:0]  puf_chal_down,
  output logic               puf_reset,
  output logic               puf_signal,
  output logic               puf_trigger,
  input  logic [NUM_PUF-1:0] puf_response,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUM_PUF-1:0] rsp_data,
  output logic [NUM_PUF-1:0] rsp_stable,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay constant until that edge, and ready may not depend on valid.

  localparam int MAX_PHASE = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE) + 1;
  localparam int ONES_W    = $clog2(NUM_EVALS + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    SETTLE,
    FIRE,
    SAMPLE,
    DONE
  } state_t;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [ONES_W-1:0]              eval_cnt;
  logic [NUM_PUF-1:0][ONES_W-1:0] ones;
  logic [NUM_PUF-1:0][ONES_W-1:0] ones_add;
  logic [NUM_PUF-1:0]             vote;
  logic [NUM_PUF-1:0]             all_same;
  logic [NUM_PUF-1:0]             sync1;
  logic [NUM_PUF-1:0]             sync2;
  logic                           active;

  // Arbiter outputs resolve asynchronously to clk, so only the second flop is ever used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
    end
  end

  // Tally including the bit being sampled now, so DONE outputs are ready on entry.
  always_comb begin
    ones_add = '0;
    vote     = '0;
    all_same = '0;
    for (int i = 0; i < NUM_PUF; i++) begin
      ones_add[i] = ones[i] + ONES_W'(sync2[i]);
      vote[i]     = ones_add[i] > ONES_W'(NUM_EVALS / 2);
      all_same[i] = (ones_add[i] == '0) || (ones_add[i] == ONES_W'(NUM_EVALS));
    end
  end

  assign active = (state == PRST) || (state == SETTLE) || (state == FIRE) || (state == SAMPLE);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      eval_cnt      <= '0;
      ones          <= '0;
      req_ready     <= 1'b1;
      puf_chal_up   <= '0;
      puf_chal_down <= '0;
      puf_reset     <= 1'b0;
      puf_signal    <= 1'b0;
      puf_trigger   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_stable    <= '0;
    end else if (abort && active) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready   <= 1'b1;
      puf_reset   <= 1'b0;
      puf_signal  <= 1'b0;
      puf_trigger <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            puf_chal_up   <= req_chal_top;
            puf_chal_down <= req_chal_bottom;
            ones          <= '0;
            eval_cnt      <= '0;
            cnt           <= CNT_W'(1);
            req_ready     <= 1'b0;
            puf_reset     <= 1'b1;
            state         <= PRST;
          end
        end
        PRST: begin
          if (cnt == '0) begin
            puf_reset  <= 1'b0;
            puf_signal <= 1'b1;
            cnt        <= CNT_W'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            puf_trigger <= 1'b1;
            cnt         <= CNT_W'(EVAL_CYCLES - 1);
            state       <= FIRE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIRE: begin
          if (cnt == '0) begin
            puf_signal  <= 1'b0;
            puf_trigger <= 1'b0;
            state       <= SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          ones     <= ones_add;
          eval_cnt <= eval_cnt + 1'b1;
          if (eval_cnt == ONES_W'(NUM_EVALS - 1)) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= vote;
            rsp_stable <= all_same;
            state      <= DONE;
          end else begin
            puf_reset <= 1'b1;
            cnt       <= CNT_W'(1);
            state     <= PRST;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_stable <= '0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdl_puf_sequencer.sv
// Directed bench for pdl_puf_sequencer: per-evaluation response patterns feed a vote model
// whose results are queued at request time and compared when the result appears.
module tb_pdl_puf_sequencer;

  localparam int NUM_PUF = 16;
  localparam int CHAL_W  = 64;
  localparam int S       = 8;
  localparam int E       = 16;
  localparam int N       = 7;
  localparam int LAT     = N * (3 + S + E);

  logic               clk;
  logic               reset_n;
  logic               abort;
  logic               req_valid;
  logic               req_ready;
  logic [CHAL_W-1:0]  req_chal_top;
  logic [CHAL_W-1:0]  req_chal_bottom;
  logic [CHAL_W-1:0]  puf_chal_up;
  logic [CHAL_W-1:0]  puf_chal_down;
  logic               puf_reset;
  logic               puf_signal;
  logic               puf_trigger;
  logic [NUM_PUF-1:0] puf_response;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [NUM_PUF-1:0] rsp_data;
  logic [NUM_PUF-1:0] rsp_stable;
  logic               busy;

  pdl_puf_sequencer #(
    .NUM_PUF(NUM_PUF), .CHAL_W(CHAL_W), .SETTLE_CYCLES(S), .EVAL_CYCLES(E), .NUM_EVALS(N)
  ) dut (
    .clk(clk), .reset_n(reset_n), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_chal_top(req_chal_top), .req_chal_bottom(req_chal_bottom),
    .puf_chal_up(puf_chal_up), .puf_chal_down(puf_chal_down),
    .puf_reset(puf_reset), .puf_signal(puf_signal), .puf_trigger(puf_trigger),
    .puf_response(puf_response),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_stable(rsp_stable), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                 n_vec;
  int                 n_err;
  logic [31:0]        exp_q[$];
  logic [NUM_PUF-1:0] pat[N];
  int                 pat_idx;
  int                 cyc;
  logic               trig_d;
  bit                 wave_en;
  int                 rst_run;
  int                 pre_run;
  int                 trig_run;
  logic [CHAL_W-1:0]  exp_top;
  logic [CHAL_W-1:0]  exp_bot;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference vote over the pattern table: {stable, data}.
  function automatic logic [31:0] vote_model();
    logic [15:0] d;
    logic [15:0] st;
    int          c;
    d  = '0;
    st = '0;
    for (int b = 0; b < NUM_PUF; b++) begin
      c = 0;
      for (int e = 0; e < N; e++) c += int'(pat[e][b]);
      d[b]  = (c > N / 2);
      st[b] = (c == 0) || (c == N);
    end
    return {st, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: advance, present the next evaluation pattern on trigger rise, check waveform.
  task automatic step();
    tick();
    cyc++;
    if (puf_trigger && !trig_d) begin
      if (pat_idx < N) puf_response = pat[pat_idx];
      pat_idx++;
    end
    if (wave_en) begin
      if (puf_reset) rst_run++;
      else if (rst_run != 0) begin
        chk("prst_len", 64'(rst_run), 64'(2));
        rst_run = 0;
      end
      if (puf_signal && !puf_trigger) pre_run++;
      if (puf_trigger && !trig_d) begin
        chk("settle_len", 64'(pre_run), 64'(S));
        pre_run = 0;
      end
      if (puf_trigger) trig_run++;
      else if (trig_run != 0) begin
        chk("fire_len", 64'(trig_run), 64'(E));
        trig_run = 0;
      end
      if (puf_trigger) chk("sig_in_fire", 64'(puf_signal), 64'(1));
      if (busy) begin
        chk("chal_up", puf_chal_up, exp_top);
        chk("chal_down", puf_chal_down, exp_bot);
      end
    end
    trig_d = puf_trigger;
  endtask

  task automatic clear_runs();
    rst_run  = 0;
    pre_run  = 0;
    trig_run = 0;
  endtask

  task automatic send_req(input logic [CHAL_W-1:0] top, input logic [CHAL_W-1:0] bot);
    int n;
    n = 0;
    while (!req_ready && n < 500) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'(1));
    req_chal_top    = top;
    req_chal_bottom = bot;
    req_valid       = 1'b1;
    exp_top         = top;
    exp_bot         = bot;
    pat_idx         = 0;
    exp_q.push_back(vote_model());
    step();
    req_valid = 1'b0;
    cyc       = 0;
    chk("accept_busy", 64'(busy), 64'(1));
    chk("accept_ready", 64'(req_ready), 64'(0));
    chk("accept_chal_up", puf_chal_up, top);
    chk("accept_prst", 64'(puf_reset), 64'(1));
  endtask

  task automatic wait_rsp();
    int          n;
    logic [31:0] e;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      step();
      n++;
    end
    chk("rsp_timeout", 64'(rsp_valid), 64'(1));
    chk("latency", 64'(cyc), 64'(LAT));
    if (exp_q.size() == 0) begin
      chk("queue_empty", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      chk("rsp_data", 64'(rsp_data), 64'(e[15:0]));
      chk("rsp_stable", 64'(rsp_stable), 64'(e[31:16]));
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ack_valid", 64'(rsp_valid), 64'(0));
    chk("ack_ready", 64'(req_ready), 64'(1));
    chk("ack_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [NUM_PUF-1:0] held_d;
    logic [NUM_PUF-1:0] held_s;
    bit                 seen;
    int                 n;
    n_vec = 0; n_err = 0; cyc = 0; pat_idx = 0; trig_d = 1'b0; wave_en = 0;
    exp_top = '0; exp_bot = '0;
    clear_runs();
    reset_n = 1'b0; abort = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_chal_top = '0; req_chal_bottom = '0; puf_response = '0;
    for (int e = 0; e < N; e++) pat[e] = '0;

    // reset state
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_puf_ctl", 64'({puf_reset, puf_signal, puf_trigger}), 64'(0));
    chk("rst_chal", puf_chal_up | puf_chal_down, 64'(0));
    chk("rst_rsp", 64'({rsp_data, rsp_stable}), 64'(0));
    reset_n = 1'b1;
    tick();

    // constant response, full waveform checking
    for (int e = 0; e < N; e++) pat[e] = 16'hA5C3;
    wave_en = 1;
    clear_runs();
    send_req({$urandom, $urandom}, {$urandom, $urandom});
    wait_rsp();
    ack();

    // bit0 high in 4 of 7 evaluations, bit1 high in 3 of 7
    for (int e = 0; e < N; e++) pat[e] = {14'd0, (e < 3), (e < 4)};
    send_req(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    wait_rsp();
    ack();

    // random per-evaluation responses
    for (int e = 0; e < N; e++) pat[e] = 16'($urandom_range(0, 16'hFFFF));
    send_req({$urandom, $urandom}, {$urandom, $urandom});
    wait_rsp();
    ack();

    // backpressure in DONE: held result, new requests and abort ignored
    for (int e = 0; e < N; e++) pat[e] = 16'($urandom_range(0, 16'hFFFF));
    send_req({$urandom, $urandom}, {$urandom, $urandom});
    wait_rsp();
    held_d = rsp_data;
    held_s = rsp_stable;
    req_valid    = 1'b1;
    req_chal_top = ~exp_top;
    for (int i = 0; i < 20; i++) begin
      abort = (i == 5);
      step();
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data", 64'(rsp_data), 64'(held_d));
      chk("bp_stable", 64'(rsp_stable), 64'(held_s));
      chk("bp_req_ready", 64'(req_ready), 64'(0));
    end
    abort     = 1'b0;
    req_valid = 1'b0;
    ack();

    // abort during the third FIRE phase
    wave_en = 0;
    send_req({$urandom, $urandom}, {$urandom, $urandom});
    n = 0;
    while (pat_idx < 3 && n < 1000) begin
      step();
      n++;
    end
    chk("third_fire_seen", 64'(pat_idx), 64'(3));
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_ready", 64'(req_ready), 64'(1));
    chk("abort_puf_ctl", 64'({puf_reset, puf_signal, puf_trigger}), 64'(0));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= rsp_valid;
    end
    chk("abort_no_rsp", 64'(seen), 64'(0));

    // asynchronous reset pulse during SETTLE
    send_req({$urandom, $urandom}, {$urandom, $urandom});
    n = 0;
    while (!(puf_signal && !puf_trigger) && n < 100) begin
      step();
      n++;
    end
    chk("settle_seen", 64'(puf_signal), 64'(1));
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_puf_ctl", 64'({puf_reset, puf_signal, puf_trigger}), 64'(0));
    chk("mid_rst_chal", puf_chal_up, 64'(0));
    #1;
    reset_n = 1'b1;
    void'(exp_q.pop_back());
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen |= rsp_valid | busy;
    end
    chk("mid_rst_idle", 64'(seen), 64'(0));

    // next request must tally from zero
    for (int e = 0; e < N; e++) pat[e] = {14'd0, (e < 3), (e < 4)};
    wave_en = 1;
    clear_runs();
    send_req({$urandom, $urandom}, {$urandom, $urandom});
    wait_rsp();
    ack();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
